// File: rtl/alu_pkg.sv
// Shared encodings for the add/subtract ALU stage: op codes, FSM states and result payload.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_SLT  = 2'b10,
        OP_SLTU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_FULL = 2'b10
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [FLAG_W-1:0] flags;   // {N,Z,C,V}
    } res_t;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic n, input logic z,
                                                     input logic c, input logic v);
        return {n, z, c, v};
    endfunction

endpackage

// File: rtl/BK_Adder_32.sv
// 32-bit Brent-Kung parallel-prefix adder with carry-in and carry-out.
module BK_Adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    localparam int unsigned W      = 32;
    localparam int unsigned LEVELS = 5;

    logic [W-1:0] gen;
    logic [W-1:0] prop;
    logic [W-1:0] grp_g;
    logic [W-1:0] grp_p;
    logic [W:0]   carry;

    // Up-sweep builds power-of-two spans, down-sweep fills in the remaining prefixes.
    always_comb begin
        gen   = a & b;
        prop  = a ^ b;
        grp_g = gen;
        grp_p = prop;
        for (int d = 0; d < int'(LEVELS); d++) begin
            for (int i = 0; i < int'(W); i++) begin
                if (((i + 1) % (2 << d)) == 0) begin
                    grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - (1 << d)]);
                    grp_p[i] = grp_p[i] & grp_p[i - (1 << d)];
                end
            end
        end
        for (int d = int'(LEVELS) - 2; d >= 0; d--) begin
            for (int i = 0; i < int'(W); i++) begin
                if ((i >= (3 << d) - 1) && (((i + 1 - (1 << d)) % (2 << d)) == 0)) begin
                    grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - (1 << d)]);
                    grp_p[i] = grp_p[i] & grp_p[i - (1 << d)];
                end
            end
        end
        carry[0] = cin;
        for (int i = 0; i < int'(W); i++) begin
            carry[i + 1] = grp_g[i] | (grp_p[i] & cin);
        end
        sum  = prop ^ carry[W-1:0];
        cout = carry[W];
    end

endmodule

// File: rtl/alu_addsub_stage.sv
// Single-cycle ADD/SUB/SLT/SLTU pipeline stage with a one-entry skid buffer for backpressure.
module alu_addsub_stage
    import alu_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags,
    output logic [TAG_W-1:0] out_tag
);

    state_e           state_q;
    state_e           state_d;
    res_t             out_q;
    res_t             skid_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [TAG_W-1:0] skid_tag_q;

    logic             sub;
    logic [31:0]      b_eff;
    logic [31:0]      sum;
    logic             cout;
    logic             flag_n;
    logic             flag_z;
    logic             flag_v;
    res_t             new_res;
    op_e              op;

    logic             in_xfer;
    logic             out_xfer;
    logic             load_out;
    logic             load_skid;
    logic             move_skid;

    assign op    = op_e'(in_op);
    assign sub   = (op != OP_ADD);
    assign b_eff = sub ? ~in_b : in_b;

    BK_Adder_32 u_adder (
        .a    (in_a),
        .b    (b_eff),
        .cin  (sub),
        .sum  (sum),
        .cout (cout)
    );

    // Flags always come from the raw adder sum; SLT/SLTU only change the result word.
    always_comb begin
        flag_n = sum[31];
        flag_z = (sum == 32'd0);
        if (sub) begin
            flag_v = (in_a[31] != in_b[31]) & (sum[31] != in_a[31]);
        end else begin
            flag_v = (in_a[31] == in_b[31]) & (sum[31] != in_a[31]);
        end
        new_res.flags = pack_flags(flag_n, flag_z, cout, flag_v);
        case (op)
            OP_SLT:  new_res.result = {31'd0, flag_n ^ flag_v};
            OP_SLTU: new_res.result = {31'd0, ~cout};
            default: new_res.result = sum;
        endcase
    end

    // Ready depends only on registered state and reset, never on out_ready.
    assign in_ready  = (state_q != ST_FULL) & ~rst;
    assign out_valid = (state_q != ST_IDLE);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    state_d  = ST_BUSY;
                    load_out = 1'b1;
                end
            end
            ST_BUSY: begin
                case ({in_xfer, out_xfer})
                    2'b11:   load_out = 1'b1;
                    2'b10: begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end
                    2'b01:   state_d = ST_IDLE;
                    default: state_d = ST_BUSY;
                endcase
            end
            ST_FULL: begin
                if (out_xfer) begin
                    state_d   = ST_BUSY;
                    move_skid = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            out_q      <= '0;
            out_tag_q  <= '0;
            skid_q     <= '0;
            skid_tag_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                out_q     <= new_res;
                out_tag_q <= in_tag;
            end else if (move_skid) begin
                out_q     <= skid_q;
                out_tag_q <= skid_tag_q;
            end
            if (load_skid) begin
                skid_q     <= new_res;
                skid_tag_q <= in_tag;
            end
        end
    end

    assign out_result = out_q.result;
    assign out_flags  = out_q.flags;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_alu_addsub_stage.sv
// Directed-vector bench for alu_addsub_stage: arithmetic/flags, backpressure ordering, reset in FULL.
module tb_alu_addsub_stage;

    localparam int unsigned TAG_W = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [3:0]       out_flags;
    logic [TAG_W-1:0] out_tag;

    int total;
    int bad;

    alu_addsub_stage #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One op with out_ready held high: checks one-cycle latency, result, flags, tag, then drain.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag,
                          input logic [31:0] exp_res, input logic [3:0] exp_flags);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        #1;
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_result"}, out_result, exp_res);
        chk({name, "_flags"}, 32'(out_flags), 32'(exp_flags));
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
        step();
        chk({name, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    task automatic offer(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_tag    = '0;
        out_ready = 1'b0;

        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Flags are {N,Z,C,V}.
        run_op("add_wrap",  2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4,  32'h0000_0000, 4'b0110);
        run_op("sub_ovf",   2'b01, 32'h8000_0000, 32'h0000_0001, 5'd5,  32'h7FFF_FFFF, 4'b0011);
        run_op("slt_neg",   2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6,  32'h0000_0001, 4'b1010);
        run_op("sltu_big",  2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 5'd7,  32'h0000_0000, 4'b1010);
        run_op("add_ovf",   2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 5'd8,  32'h8000_0000, 4'b1001);
        run_op("sub_zero",  2'b01, 32'h0000_0005, 32'h0000_0005, 5'd9,  32'h0000_0000, 4'b0110);
        run_op("sub_borrow",2'b01, 32'h0000_0003, 32'h0000_0005, 5'd10, 32'hFFFF_FFFE, 4'b1000);
        run_op("sltu_lt",   2'b11, 32'h0000_0003, 32'h0000_0005, 5'd11, 32'h0000_0001, 4'b1000);
        run_op("slt_ge",    2'b10, 32'h0000_0005, 32'h0000_0003, 5'd12, 32'h0000_0000, 4'b0010);
        run_op("add_mix",   2'b00, 32'h1234_5678, 32'h0F0F_0F0F, 5'd13, 32'h2143_6587, 4'b0000);

        // Backpressure: tags 1,2 fill the stage, tag 3 must wait, then order is 1,2,3.
        out_ready = 1'b0;
        offer(2'b00, 32'd1, 32'd1, 5'd1);
        #1;
        chk("bp_ready_t1", 32'(in_ready), 32'd1);
        step();
        offer(2'b01, 32'd10, 32'd3, 5'd2);
        #1;
        chk("bp_ready_t2", 32'(in_ready), 32'd1);
        step();
        offer(2'b00, 32'd100, 32'd200, 5'd3);
        #1;
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        chk("bp_hold_tag", 32'(out_tag), 32'd1);
        step();
        chk("bp_stall_valid", 32'(out_valid), 32'd1);
        chk("bp_stall_tag", 32'(out_tag), 32'd1);
        chk("bp_stall_result", out_result, 32'd2);
        chk("bp_stall_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_t2_tag", 32'(out_tag), 32'd2);
        chk("bp_t2_result", out_result, 32'd7);
        chk("bp_t2_flags", 32'(out_flags), 32'h2);
        chk("bp_t2_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_t3_valid", 32'(out_valid), 32'd1);
        chk("bp_t3_tag", 32'(out_tag), 32'd3);
        chk("bp_t3_result", out_result, 32'd300);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Reset while FULL discards both held results.
        out_ready = 1'b0;
        offer(2'b00, 32'd5, 32'd6, 5'd20);
        step();
        offer(2'b00, 32'd7, 32'd8, 5'd21);
        step();
        in_valid = 1'b0;
        #1;
        chk("full_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_full_ready_low", 32'(in_ready), 32'd0);
        step();
        chk("rst_full_valid", 32'(out_valid), 32'd0);
        chk("rst_full_tag", 32'(out_tag), 32'd0);
        chk("rst_full_result", out_result, 32'd0);
        chk("rst_hold_ready_low", 32'(in_ready), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_full_ready_back", 32'(in_ready), 32'd1);
        step();
        chk("no_stale_1", 32'(out_valid), 32'd0);
        step();
        chk("no_stale_2", 32'(out_valid), 32'd0);

        // Stage still works after the mid-operation reset.
        run_op("post_rst_add", 2'b00, 32'd40, 32'd2, 5'd30, 32'd42, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_addsub_stage.md
ALU_ADDSUB_STAGE -- requirements
Module: alu_addsub_stage

Interface
REQ-001 SHALL have parameter: TAG_W, default 5, width of destination-register tag carried with each operation.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  upstream operation valid.
REQ-005 SHALL have port: in_ready  output  1  stage can accept an operation.
REQ-006 SHALL have port: in_op  input  2  operation: 00 ADD, 01 SUB, 10 SLT, 11 SLTU.
REQ-007 SHALL have port: in_a  input  32  operand A.
REQ-008 SHALL have port: in_b  input  32  operand B.
REQ-009 SHALL have port: in_tag  input  TAG_W  tag, passed through unchanged.
REQ-010 SHALL have port: out_valid  output  1  result valid.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port: out_result  output  32  result word.
REQ-013 SHALL have port: out_flags  output  4  {N,Z,C,V}.
REQ-014 SHALL have port: out_tag  output  TAG_W  tag of out_result.

Function
REQ-015 SHALL treat input transfer as in_valid&in_ready and output transfer as out_valid&out_ready, both in the same clk edge.
REQ-016 SHALL compute Y = A+B with Cin=0 for ADD, and Y = A+~B+1 with Cin=1 for SUB/SLT/SLTU.
REQ-017 SHALL set C = adder carry-out; for subtract C=1 means no borrow (A >= B unsigned).
REQ-018 SHALL set V = (A31==B31)&(Y31!=A31) for ADD and (A31!=B31)&(Y31!=A31) for subtract ops.
REQ-019 SHALL set N = Y31 and Z = (Y==0), all from the adder sum, for every op.
REQ-020 SHALL output out_result = Y for ADD/SUB, {31'b0,N^V} for SLT, {31'b0,~C} for SLTU.
REQ-021 SHALL have latency exactly 1 cycle: an operation accepted at edge k appears on outputs after edge k when no older result is pending.
REQ-022 SHALL implement FSM IDLE (no result held), BUSY (output register valid), FULL (output register and skid register valid).
REQ-023 SHALL transition IDLE->BUSY on input transfer.
REQ-024 SHALL stay BUSY on simultaneous input+output transfer, loading the new result.
REQ-025 SHALL go BUSY->FULL on input transfer without output transfer, writing the skid register.
REQ-026 SHALL go BUSY->IDLE on output transfer without input transfer.
REQ-027 SHALL go FULL->BUSY on output transfer, moving skid to the output register.
REQ-028 SHALL drive in_ready = (state!=FULL) & ~rst from registered state only, with no combinational path from out_ready.
REQ-029 SHALL hold out_result/out_flags/out_tag stable while out_valid=1 and out_ready=0.
REQ-030 SHALL deliver results in acceptance order, never dropping or duplicating one.

Reset
REQ-031 SHALL, on rst high at a clk edge, set state IDLE, out_valid 0, out_result 0, out_flags 0, out_tag 0, and clear the skid register.
REQ-032 SHALL discard any held results when reset is asserted mid-operation, including in FULL.
REQ-033 SHALL hold in_ready 0 while rst is high and 1 from the first cycle after deassertion.

Structure
REQ-034 SHALL place the op encodings and FSM state encodings in shared package alu_pkg.
REQ-035 SHALL instantiate exactly one existing BK_Adder_32 on the input side, feeding operand A, operand B, and Cin, with flag/result logic and registers in this module.

Verification
REQ-036 SHALL be checked with: ADD 0xFFFFFFFF+0x00000001 -> result 0x00000000, flags N0 Z1 C1 V0, out_valid one cycle after transfer.
REQ-037 SHALL be checked with: SUB 0x80000000-0x00000001 -> result 0x7FFFFFFF, flags N0 Z0 C1 V1.
REQ-038 SHALL be checked with: SLT A=0xFFFFFFFF B=0x00000001 -> result 1; SLTU same operands -> result 0 (C=1).
REQ-039 SHALL be checked with: out_ready=0, three ops with tags 1,2,3 offered -> in_ready falls after tag 2 is accepted; with out_ready=1, tags emerge as 1,2,3 with correct results.
REQ-040 SHALL be checked with: rst pulsed while in FULL -> out_valid 0 after the edge, no stale tag emerges, in_ready 1 one cycle after rst falls.
